// File: rtl/fetch_decode_stage.sv
// Instruction fetch plus IF/ID register with a one-entry skid buffer and immediate-select decode.
// Optional: define FETCH_UNCOND_REDIRECT_EN to redirect the PC on B instructions entering IF/ID.
module fetch_decode_stage (
  input  logic        CLK,
  input  logic        resetl,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [31:0] Instr,
  output logic [63:0] PC_out,
  output logic        id_valid,
  output logic [25:0] Imm26,
  output logic [2:0]  ImmCtrl
);

  typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;

  state_t      state, state_next;
  logic [63:0] pc;
  logic [31:0] skid_instr;
  logic [63:0] skid_pc;
  logic        skid_valid;

  logic        accept, park, drain, load_id;
  logic [31:0] wr_instr;
  logic [63:0] wr_pc;

`ifdef FETCH_UNCOND_REDIRECT_EN
  logic        wr_is_b;
  logic [63:0] wr_b_target;
`endif

  // Priority: branch_taken > stall > imem_ready
  always_comb begin
    accept   = (state == FETCH) && imem_ready && !branch_taken && !stall;
    park     = (state == FETCH) && imem_ready && !branch_taken && stall;
    drain    = (state == PEND) && skid_valid && !branch_taken && !stall;
    load_id  = accept || drain;
    wr_instr = drain ? skid_instr : imem_rdata;
    wr_pc    = drain ? skid_pc : pc;
  end

`ifdef FETCH_UNCOND_REDIRECT_EN
  always_comb begin
    wr_is_b     = (wr_instr[31:26] == 6'b000101);
    wr_b_target = wr_pc + {{36{wr_instr[25]}}, wr_instr[25:0], 2'b00};
  end
`endif

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (park) state_next = PEND;
      PEND:    if (drain) state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (branch_taken) state_next = FETCH;
  end

  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc         <= 64'd0;
      Instr      <= 32'd0;
      PC_out     <= 64'd0;
      id_valid   <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 64'd0;
      skid_valid <= 1'b0;
    end else if (branch_taken) begin
      pc         <= branch_target & ~64'd3;
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (accept || park) pc <= pc + 64'd4;
`ifdef FETCH_UNCOND_REDIRECT_EN
      if (load_id && wr_is_b) pc <= wr_b_target;
`endif
      if (park) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
        skid_valid <= 1'b1;
      end
      if (drain) skid_valid <= 1'b0;
      if (load_id) begin
        Instr    <= wr_instr;
        PC_out   <= wr_pc;
        id_valid <= 1'b1;
      end
    end
  end

  // MOVZ is checked first so it wins over every other opcode match
  always_comb begin
    ImmCtrl = 3'b000;
    if (Instr[31:23] == 9'b110100101)
      ImmCtrl = {1'b1, Instr[22:21]};
    else if (Instr[31:24] == 8'b10110100 || Instr[31:24] == 8'b10110101)
      ImmCtrl = 3'b011;
    else if (Instr[31:26] == 6'b000101)
      ImmCtrl = 3'b010;
    else if (Instr[31:21] == 11'b11111000010 || Instr[31:21] == 11'b11111000000)
      ImmCtrl = 3'b001;
  end

  assign Imm26 = Instr[25:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: reset, streaming fetch, stall/skid, branch, reset pulse, B redirect.
module tb_fetch_decode_stage;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] Instr;
  logic [63:0] PC_out;
  logic        id_valid;
  logic [25:0] Imm26;
  logic [2:0]  ImmCtrl;

  int vectors = 0;
  int miscompares = 0;

  fetch_decode_stage dut (
    .CLK(CLK), .resetl(resetl),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .Instr(Instr), .PC_out(PC_out), .id_valid(id_valid),
    .Imm26(Imm26), .ImmCtrl(ImmCtrl)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    resetl = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    step(); step();
    chk("rst_req",   {63'd0, imem_req}, 64'd0);
    chk("rst_addr",  imem_addr, 64'd0);
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_instr", {32'd0, Instr}, 64'd0);
    chk("rst_pcout", PC_out, 64'd0);

    // Release into IDLE with a stray response present
    resetl = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("idle_req", {63'd0, imem_req}, 64'd0);
    step();
    chk("f0_req",   {63'd0, imem_req}, 64'd1);
    chk("f0_addr",  imem_addr, 64'h0);
    chk("f0_valid", {63'd0, id_valid}, 64'd0);

    imem_rdata = 32'h91000421; step();
    chk("s1_instr", {32'd0, Instr}, 64'h91000421);
    chk("s1_pcout", PC_out, 64'h0);
    chk("s1_valid", {63'd0, id_valid}, 64'd1);
    chk("s1_ictl",  {61'd0, ImmCtrl}, 64'd0);
    chk("s1_addr",  imem_addr, 64'h4);

    imem_rdata = 32'hF84083E1; step();
    chk("s2_instr", {32'd0, Instr}, 64'hF84083E1);
    chk("s2_pcout", PC_out, 64'h4);
    chk("s2_ictl",  {61'd0, ImmCtrl}, 64'd1);
    chk("s2_addr",  imem_addr, 64'h8);

    imem_rdata = 32'h8B020020; step();
    chk("s3_ictl",  {61'd0, ImmCtrl}, 64'd0);
    imem_rdata = 32'hB4000040; step();
    chk("s4_ictl",  {61'd0, ImmCtrl}, 64'd3);
    chk("s4_addr",  imem_addr, 64'h10);

    // Response arrives under stall: goes to skid buffer
    stall = 1'b1; imem_rdata = 32'hD2A00020; step();
    imem_ready = 1'b0;
    chk("pend_req",   {63'd0, imem_req}, 64'd0);
    chk("pend_instr", {32'd0, Instr}, 64'hB4000040);
    chk("pend_pcout", PC_out, 64'hC);
    step();
    chk("pend2_instr", {32'd0, Instr}, 64'hB4000040);
    chk("pend2_req",   {63'd0, imem_req}, 64'd0);
    stall = 1'b0; step();
    chk("drain_instr", {32'd0, Instr}, 64'hD2A00020);
    chk("drain_pcout", PC_out, 64'h10);
    chk("drain_ictl",  {61'd0, ImmCtrl}, 64'd5);
    chk("drain_imm26", {38'd0, Imm26}, 64'h2A00020);
    chk("drain_addr",  imem_addr, 64'h14);
    chk("drain_req",   {63'd0, imem_req}, 64'd1);

    // Stall with no response holds request and IF/ID
    stall = 1'b1; step();
    chk("hold_req",   {63'd0, imem_req}, 64'd1);
    chk("hold_addr",  imem_addr, 64'h14);
    chk("hold_instr", {32'd0, Instr}, 64'hD2A00020);
    chk("hold_valid", {63'd0, id_valid}, 64'd1);

    // Branch coincident with response
    stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h12345678;
    branch_taken = 1'b1; branch_target = 64'h103; step();
    branch_taken = 1'b0; imem_ready = 1'b0;
    chk("br_valid", {63'd0, id_valid}, 64'd0);
    chk("br_addr",  imem_addr, 64'h100);
    chk("br_req",   {63'd0, imem_req}, 64'd1);

    // B instruction at 0x20
    branch_taken = 1'b1; branch_target = 64'h20; step();
    branch_taken = 1'b0;
    chk("b_addr0", imem_addr, 64'h20);
    imem_ready = 1'b1; imem_rdata = 32'h17FFFFFF; step();
    imem_ready = 1'b0;
    chk("b_instr", {32'd0, Instr}, 64'h17FFFFFF);
    chk("b_pcout", PC_out, 64'h20);
    chk("b_ictl",  {61'd0, ImmCtrl}, 64'd2);
`ifdef FETCH_UNCOND_REDIRECT_EN
    chk("b_next", imem_addr, 64'h1C);
`else
    chk("b_next", imem_addr, 64'h24);
`endif

    // Branch while parked in PEND discards the skid entry
    imem_ready = 1'b1; stall = 1'b1; imem_rdata = 32'h11111111; step();
    imem_ready = 1'b0;
    chk("p2_req", {63'd0, imem_req}, 64'd0);
    branch_taken = 1'b1; branch_target = 64'h40; step();
    branch_taken = 1'b0;
    chk("pbr_valid", {63'd0, id_valid}, 64'd0);
    chk("pbr_addr",  imem_addr, 64'h40);
    chk("pbr_req",   {63'd0, imem_req}, 64'd1);
    stall = 1'b0; step();
    chk("pbr_valid2", {63'd0, id_valid}, 64'd0);
    chk("pbr_instr",  {32'd0, Instr}, 64'h17FFFFFF);

    // Asynchronous reset pulse mid-request
    resetl = 1'b0; #2;
    chk("ap_req",   {63'd0, imem_req}, 64'd0);
    chk("ap_addr",  imem_addr, 64'd0);
    chk("ap_valid", {63'd0, id_valid}, 64'd0);
    chk("ap_instr", {32'd0, Instr}, 64'd0);
    chk("ap_pcout", PC_out, 64'd0);
    resetl = 1'b1; step();
    chk("ap_f_req",  {63'd0, imem_req}, 64'd1);
    chk("ap_f_addr", imem_addr, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
